// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : opcode, state and width definitions shared by the ALU sequencer
// Revision : 1.0
// ============================================================================
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_SHIFT = 2'b10,
    OP_AND   = 2'b11
  } alu_op_t;

  localparam int ALU_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    DRIVE   = 2'b01,
    CAPTURE = 2'b10,
    OUT     = 2'b11
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// alu_op_sequencer : one-op-in-flight valid/ready wrapper around a
//                    combinational 4-bit ALU with settle delay and op counter
// Revision : 1.0
// ============================================================================
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int TAG_W         = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [ALU_W-1:0] cmd_a,
  input  logic [ALU_W-1:0] cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [ALU_W-1:0] alu_a,
  output logic [ALU_W-1:0] alu_b,
  output logic [1:0]       alu_s,
  input  logic [ALU_W-1:0] alu_f,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ALU_W-1:0] res_f,
  output logic [1:0]       res_op,
  output logic [TAG_W-1:0] res_tag,
  output logic             busy,
  output logic [15:0]      op_count
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  seq_state_t       state_q,    state_d;
  logic [3:0]       cnt_q,      cnt_d;
  logic [ALU_W-1:0] alu_a_q,    alu_a_d;
  logic [ALU_W-1:0] alu_b_q,    alu_b_d;
  alu_op_t          alu_s_q,    alu_s_d;
  logic [TAG_W-1:0] tag_q,      tag_d;
  logic [ALU_W-1:0] res_f_q,    res_f_d;
  logic [1:0]       res_op_q,   res_op_d;
  logic [TAG_W-1:0] res_tag_q,  res_tag_d;
  logic [15:0]      op_count_q, op_count_d;

  // Gated with rst_n so no command is taken while reset is being held.
  assign cmd_ready = rst_n && (state_q == IDLE);
  assign res_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_s     = alu_s_q;
  assign res_f     = res_f_q;
  assign res_op    = res_op_q;
  assign res_tag   = res_tag_q;
  assign op_count  = op_count_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_s_d    = alu_s_q;
    tag_d      = tag_q;
    res_f_d    = res_f_q;
    res_op_d   = res_op_q;
    res_tag_d  = res_tag_q;
    op_count_d = op_count_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          alu_a_d = cmd_a;
          alu_b_d = cmd_b;
          alu_s_d = alu_op_t'(cmd_op);
          tag_d   = cmd_tag;
          cnt_d   = SETTLE_LOAD;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == 4'd0) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      CAPTURE: begin
        res_f_d   = alu_f;
        res_op_d  = alu_s_q;
        res_tag_d = tag_q;
        state_d   = OUT;
      end
      OUT: begin
        if (res_ready) begin
          op_count_d = op_count_q + 16'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_s_q    <= OP_ADD;
      tag_q      <= '0;
      res_f_q    <= '0;
      res_op_q   <= '0;
      res_tag_q  <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_s_q    <= alu_s_d;
      tag_q      <= tag_d;
      res_f_q    <= res_f_d;
      res_op_q   <= res_op_d;
      res_tag_q  <= res_tag_d;
      op_count_q <= op_count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// tb_alu_op_sequencer : scoreboard bench for alu_op_sequencer (settle 1 and 4)
// Revision : 1.0
// ============================================================================
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  // Default-settle instance
  logic        cmd_valid, cmd_ready, res_valid, res_ready, busy;
  logic [1:0]  cmd_op, alu_s, res_op;
  logic [3:0]  cmd_a, cmd_b, alu_a, alu_b, alu_f, res_f;
  logic [2:0]  cmd_tag, res_tag;
  logic [15:0] op_count;

  // SETTLE_CYCLES = 4 instance
  logic        cmd_valid4, cmd_ready4, res_valid4, res_ready4, busy4;
  logic [1:0]  cmd_op4, alu_s4, res_op4;
  logic [3:0]  cmd_a4, cmd_b4, alu_a4, alu_b4, alu_f4, res_f4, jit4;
  logic [2:0]  cmd_tag4, res_tag4;
  logic [15:0] op_count4;

  typedef struct packed {
    logic [3:0] f;
    logic [1:0] op;
    logic [2:0] tag;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference 4-bit ALU sitting outside the sequencer
  function automatic logic [3:0] alu_model(input logic [1:0] s, input logic [3:0] a,
                                           input logic [3:0] b);
    case (s)
      2'b00:   alu_model = a + b;
      2'b01:   alu_model = a - b;
      2'b10:   alu_model = a << b[1:0];
      default: alu_model = a & b;
    endcase
  endfunction

  assign alu_f  = alu_model(alu_s, alu_a, alu_b);
  assign alu_f4 = alu_model(alu_s4, alu_a4, alu_b4) ^ jit4;

  alu_op_sequencer #(.SETTLE_CYCLES(1), .TAG_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_f(alu_f),
    .res_valid(res_valid), .res_ready(res_ready), .res_f(res_f),
    .res_op(res_op), .res_tag(res_tag), .busy(busy), .op_count(op_count)
  );

  alu_op_sequencer #(.SETTLE_CYCLES(4), .TAG_W(3)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4), .cmd_op(cmd_op4),
    .cmd_a(cmd_a4), .cmd_b(cmd_b4), .cmd_tag(cmd_tag4),
    .alu_a(alu_a4), .alu_b(alu_b4), .alu_s(alu_s4), .alu_f(alu_f4),
    .res_valid(res_valid4), .res_ready(res_ready4), .res_f(res_f4),
    .res_op(res_op4), .res_tag(res_tag4), .busy(busy4), .op_count(op_count4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                           input logic [2:0] tag);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_tag   = tag;
  endtask

  // Scoreboard: push on accepted command, pop and compare on result handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid && cmd_ready)
        exp_q.push_back('{f: alu_model(cmd_op, cmd_a, cmd_b), op: cmd_op, tag: cmd_tag});
      if (res_valid && exp_q.size() == 0) begin
        check("res_spurious", {31'd0, res_valid}, 32'd0);
      end else if (res_valid && res_ready) begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_res_f", {28'd0, res_f}, {28'd0, e.f});
        check("sb_res_op", {30'd0, res_op}, {30'd0, e.op});
        check("sb_res_tag", {29'd0, res_tag}, {29'd0, e.tag});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [1:0] b2b_op  [3] = '{2'b01, 2'b10, 2'b11};
  logic [3:0] b2b_a   [3] = '{4'h2, 4'h1, 4'hE};
  logic [3:0] b2b_b   [3] = '{4'h5, 4'h3, 4'h7};
  int         acc_cyc [3];

  initial begin
    int lat;
    int w;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0; res_ready = 1'b0;
    cmd_valid4 = 1'b0; cmd_op4 = '0; cmd_a4 = '0; cmd_b4 = '0; cmd_tag4 = '0;
    res_ready4 = 1'b0; jit4 = '0;
    tick(2);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_op_count", {16'd0, op_count}, 32'd0);
    check("rst_alu_a", {28'd0, alu_a}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Basic add: 0101 + 1100 -> 0001, result two cycles after accept
    res_ready = 1'b1;
    drive_cmd(2'b00, 4'b0101, 4'b1100, 3'd3);
    tick(1);
    cmd_valid = 1'b0;
    check("t1_alu_a", {28'd0, alu_a}, 32'h5);
    check("t1_alu_b", {28'd0, alu_b}, 32'hC);
    check("t1_alu_s", {30'd0, alu_s}, 32'h0);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    tick(1);
    check("t1_early_valid", {31'd0, res_valid}, 32'd0);
    tick(1);
    check("t1_res_valid", {31'd0, res_valid}, 32'd1);
    check("t1_res_f", {28'd0, res_f}, 32'h1);
    check("t1_res_tag", {29'd0, res_tag}, 32'd3);
    tick(1);
    check("t1_op_count", {16'd0, op_count}, 32'd1);
    check("t1_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Downstream stall: 1001 - 0111 -> 0010 held while res_ready is low
    res_ready = 1'b0;
    drive_cmd(2'b01, 4'b1001, 4'b0111, 3'd5);
    tick(1);
    cmd_valid = 1'b0;
    tick(2);
    drive_cmd(2'b11, 4'h0, 4'h0, 3'd1);
    for (int i = 0; i < 5; i++) begin
      check("t2_res_valid", {31'd0, res_valid}, 32'd1);
      check("t2_res_f", {28'd0, res_f}, 32'h2);
      check("t2_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("t2_alu_a_hold", {28'd0, alu_a}, 32'h9);
      tick(1);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    tick(1);
    check("t2_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("t2_op_count", {16'd0, op_count}, 32'd2);

    // Back-to-back with cmd_valid held high
    for (int i = 0; i < 3; i++) begin
      drive_cmd(b2b_op[i], b2b_a[i], b2b_b[i], 3'(i + 1));
      w = 0;
      while (!cmd_ready && w < 20) begin
        tick(1);
        w++;
      end
      if (w >= 20) check("t4_accept_timeout", {31'd0, cmd_ready}, 32'd1);
      acc_cyc[i] = cyc;
      tick(1);
    end
    cmd_valid = 1'b0;
    tick(4);
    check("t4_spacing0", 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
    check("t4_spacing1", 32'(acc_cyc[2] - acc_cyc[1]), 32'd4);
    check("t4_op_count", {16'd0, op_count}, 32'd5);

    // Reset during DRIVE discards the in-flight command
    drive_cmd(2'b11, 4'b1111, 4'b1100, 3'd6);
    tick(1);
    cmd_valid = 1'b0;
    check("t5_busy_drive", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    tick(1);
    check("t5_alu_a", {28'd0, alu_a}, 32'd0);
    check("t5_alu_b", {28'd0, alu_b}, 32'd0);
    check("t5_alu_s", {30'd0, alu_s}, 32'd0);
    check("t5_res_f", {28'd0, res_f}, 32'd0);
    check("t5_res_op", {30'd0, res_op}, 32'd0);
    check("t5_res_tag", {29'd0, res_tag}, 32'd0);
    check("t5_op_count", {16'd0, op_count}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_res_valid", {31'd0, res_valid}, 32'd0);
    check("t5_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("t5_rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    tick(4);
    check("t5_no_result", {31'd0, res_valid}, 32'd0);
    drive_cmd(2'b00, 4'h3, 4'h4, 3'd2);
    tick(1);
    cmd_valid = 1'b0;
    tick(3);
    check("t5_op_count_after", {16'd0, op_count}, 32'd1);

    // op_count wrap
    force dut.op_count_q = 16'hFFFF;
    #1;
    release dut.op_count_q;
    check("t6_preload", {16'd0, op_count}, 32'hFFFF);
    drive_cmd(2'b10, 4'h1, 4'h1, 3'd7);
    tick(1);
    cmd_valid = 1'b0;
    tick(3);
    check("t6_wrap", {16'd0, op_count}, 32'd0);

    // SETTLE_CYCLES = 4: ALU output moves each DRIVE cycle, held through CAPTURE
    res_ready4 = 1'b1;
    cmd_valid4 = 1'b1; cmd_op4 = 2'b10; cmd_a4 = 4'b0011; cmd_b4 = 4'b1010; cmd_tag4 = 3'd4;
    tick(1);
    cmd_valid4 = 1'b0;
    check("t3_alu_a", {28'd0, alu_a4}, 32'h3);
    lat = 0;
    for (int k = 1; k <= 10 && !res_valid4; k++) begin
      if (k <= 4) jit4 = 4'(k);
      tick(1);
      lat = k;
    end
    check("t3_latency", 32'(lat), 32'd5);
    check("t3_res_f", {28'd0, res_f4}, 32'(4'hC ^ 4'h4));
    check("t3_res_op", {30'd0, res_op4}, 32'h2);
    check("t3_res_tag", {29'd0, res_tag4}, 32'd4);
    tick(1);
    check("t3_op_count", {16'd0, op_count4}, 32'd1);
    check("t3_cmd_ready", {31'd0, cmd_ready4}, 32'd1);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Upstream command stage for the 4-bit ALU. Accepts operation requests (opcode, two operands, tag) over a valid/ready handshake, holds the ALU inputs stable for a programmable settle time, captures the ALU result, and presents it downstream over a second valid/ready handshake. The block converts the purely combinational ALU into a flow-controlled, one-op-in-flight pipeline element and counts completed operations.

## Interface
- `SETTLE_CYCLES`, default 1: cycles the ALU inputs are held before `f` is sampled; legal range 1–15.
- `TAG_W`, default 3: width of the pass-through command tag.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_op` in 2: opcode; 00 add, 01 sub, 10 shift, 11 and.
- `cmd_a` in 4: operand A.
- `cmd_b` in 4: operand B.
- `cmd_tag` in `TAG_W`: tag echoed with the result.
- `alu_a` out 4: drives ALU `a`.
- `alu_b` out 4: drives ALU `b`.
- `alu_s` out 2: drives ALU `s`.
- `alu_f` in 4: ALU result `f`.
- `res_valid` out 1: result present.
- `res_ready` in 1: downstream accepts result.
- `res_f` out 4: captured result.
- `res_op` out 2: opcode of the result.
- `res_tag` out `TAG_W`: tag of the result.
- `busy` out 1: high in any state other than IDLE.
- `op_count` out 16: completed results (handshakes on `res`), wraps at 16'hFFFF→0.

## Operation
- FSM states: IDLE, DRIVE, CAPTURE, OUT.
- IDLE: `cmd_ready`=1. On `cmd_valid && cmd_ready`, register `cmd_op/a/b/tag` into `alu_s/a/b` and the tag register, load settle counter with `SETTLE_CYCLES-1`, and go to DRIVE.
- DRIVE: ALU inputs held constant. Counter decrements each cycle. At 0, go to CAPTURE.
- CAPTURE: one cycle. Sample `alu_f` into `res_f`, copy opcode and tag into `res_op`/`res_tag`, and go to OUT.
- OUT: `res_valid`=1. `res_f`/`res_op`/`res_tag` are stable until the handshake. On `res_valid && res_ready`, increment `op_count` and go to IDLE.
- `cmd_ready` is 0 in every state except IDLE. There is no overlap: exactly one operation is in flight.
- `alu_a/b/s` keep the last command's values in IDLE and OUT; they change only on command accept.
- No arithmetic is performed here. `alu_f` is captured verbatim, 4 bits, with no carry or flags.
- Opcode 11 and all other codes pass through unchanged. There are no illegal opcodes.
- Reset (rst_n=0 at a rising edge), in any state including mid-operation:
  - The state goes to IDLE and the in-flight command is discarded.
  - `alu_a`, `alu_b`, `alu_s`, `res_f`, `res_op`, `res_tag`, and `op_count` are cleared to 0.
  - `res_valid`=0 and `busy`=0.
  - `cmd_ready`=0 while `rst_n` is low, and 1 in the first cycle after release.

## Timing
- Accept edge E0. `alu_*` carry the new values from E0 onward.
- DRIVE occupies `SETTLE_CYCLES` cycles and CAPTURE samples at edge E0+`SETTLE_CYCLES`+1.
- `res_valid` rises after edge E0+`SETTLE_CYCLES`+1. This is 2 cycles after accept for the default setting.
- If `res_ready` is held high, the result is consumed in its first OUT cycle. `cmd_ready` rises the following cycle.
- Maximum throughput is one operation per `SETTLE_CYCLES`+3 cycles.
- `res_ready` low stalls OUT indefinitely. `cmd_valid` is ignored while `cmd_ready`=0.
- `op_count` updates on the same edge as the result handshake.

## Structure
- Shared package `alu_pkg` holds:
  - `alu_op_t` enum with OP_ADD=2'b00, OP_SUB=2'b01, OP_SHIFT=2'b10, OP_AND=2'b11.
  - `localparam ALU_W = 4`.
  - `seq_state_t` enum with IDLE, DRIVE, CAPTURE, OUT.
- The ALU itself stays outside this block and is wired at the parent level.
- There is no sub-module. The settle counter and `op_count` are inline.

## Test plan
- Reset release, then `cmd_valid`=1 with op=00, a=0101, b=1100, tag=3. Check `alu_a`=0101, `alu_b`=1100, `alu_s`=00 after accept. With the bench model returning `f`=0001, check `res_valid` high 2 cycles later with `res_f`=0001, `res_tag`=3, and `op_count`=1 after the handshake.
- op=01, a=1001, b=0111, and hold `res_ready`=0 for 5 cycles. `res_valid` stays high, `res_f` stays stable, and `cmd_ready` stays 0. Raise `res_ready`: the result is consumed and `cmd_ready`=1 the next cycle.
- `SETTLE_CYCLES`=4 with op=10, a=0011, b=1010. The model changes `alu_f` every cycle. The captured `res_f` must equal the model value in the 4th DRIVE cycle, and `res_valid` rises 5 cycles after accept.
- Back-to-back: `cmd_valid` held high for 3 commands with `res_ready`=1. Commands are accepted every 4 cycles (default setting), tags are returned in order, and `op_count`=3.
- Assert `rst_n`=0 during DRIVE of op=11, a=1111, b=1100. Next cycle, all outputs are 0, `busy`=0, and no result is ever emitted. After release, `cmd_ready`=1 and the next command completes normally.
- Preload `op_count` to 16'hFFFF via 65535 operations (or a force). One more result handshake wraps it to 0.
